timing_fsm: RTL and testbench



---
 rtl/timing_fsm_pkg.sv | 72 +++++++
 rtl/timing_fsm_bank_timing.sv | 131 +++++++++++++
 rtl/timing_fsm.sv | 100 ++++++++++
 tb/tb_timing_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_fsm_pkg.sv
// -----------------------------------------------------------------------------
// timing_fsm_pkg
// Shared definitions for the per-bank DRAM timing tracker:
//   - bank_state_e : 5-bit per-bank state codes exposed on BankFSM
//   - CMD_*        : bit positions inside the 19-bit one-hot command vector
//   - bank_cmd_e   : reduced command set that actually reaches a bank
//   - cnt_width()  : width of a down-counter able to hold the longest duration
// -----------------------------------------------------------------------------
package timing_fsm_pkg;

  typedef enum logic [4:0] {
    ST_IDLE        = 5'h00,
    ST_ACTIVATING  = 5'h01,
    ST_ACTIVE      = 5'h03,
    ST_PRECHARGING = 5'h0a,
    ST_READING     = 5'h0b,
    ST_READING_AP  = 5'h0c,
    ST_REFRESHING  = 5'h0d,
    ST_WRITING     = 5'h12,
    ST_WRITING_AP  = 5'h13
  } bank_state_e;

  localparam int unsigned CMD_NUM = 19;

  localparam logic [4:0] CMD_ACT  = 5'd18;
  localparam logic [4:0] CMD_BST  = 5'd17;
  localparam logic [4:0] CMD_CFG  = 5'd16;
  localparam logic [4:0] CMD_CKEH = 5'd15;
  localparam logic [4:0] CMD_CKEL = 5'd14;
  localparam logic [4:0] CMD_DPD  = 5'd13;
  localparam logic [4:0] CMD_DPDX = 5'd12;
  localparam logic [4:0] CMD_MRR  = 5'd11;
  localparam logic [4:0] CMD_MRW  = 5'd10;
  localparam logic [4:0] CMD_PD   = 5'd9;
  localparam logic [4:0] CMD_PDX  = 5'd8;
  localparam logic [4:0] CMD_PR   = 5'd7;
  localparam logic [4:0] CMD_PRA  = 5'd6;
  localparam logic [4:0] CMD_RD   = 5'd5;
  localparam logic [4:0] CMD_RDA  = 5'd4;
  localparam logic [4:0] CMD_REF  = 5'd3;
  localparam logic [4:0] CMD_SRF  = 5'd2;
  localparam logic [4:0] CMD_WR   = 5'd1;
  localparam logic [4:0] CMD_WRA  = 5'd0;

  // Commands that can change a bank's state; everything else collapses to NONE.
  typedef enum logic [3:0] {
    BCMD_NONE = 4'd0,
    BCMD_ACT  = 4'd1,
    BCMD_PR   = 4'd2,
    BCMD_PRA  = 4'd3,
    BCMD_RD   = 4'd4,
    BCMD_RDA  = 4'd5,
    BCMD_REF  = 4'd6,
    BCMD_WR   = 4'd7,
    BCMD_WRA  = 4'd8
  } bank_cmd_e;

  // Bits needed to hold the largest of the given cycle counts (at least 1).
  function automatic int unsigned cnt_width(input int unsigned d0, input int unsigned d1,
                                            input int unsigned d2, input int unsigned d3,
                                            input int unsigned d4, input int unsigned d5);
    int unsigned mx;
    mx = d0;
    if (d1 > mx) mx = d1;
    if (d2 > mx) mx = d2;
    if (d3 > mx) mx = d3;
    if (d4 > mx) mx = d4;
    if (d5 > mx) mx = d5;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/timing_fsm_bank_timing.sv
// -----------------------------------------------------------------------------
// bank_timing
// State register, residency down-counter and transition logic of one bank.
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  synchronous active-low reset
//   cmd_i    in  command already filtered for this bank (NONE if not addressed)
//   state_o  out registered 5-bit state code
// -----------------------------------------------------------------------------
module bank_timing
  import timing_fsm_pkg::*;
#(
  parameter int unsigned BL    = 8,
  parameter int unsigned T_RCD = 17,
  parameter int unsigned T_WR  = 14,
  parameter int unsigned T_RP  = 17,
  parameter int unsigned T_RFC = 34,
  parameter int unsigned CW    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  bank_cmd_e  cmd_i,
  output logic [4:0] state_o
);

  bank_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;

  // The counter is loaded with the full residency on entry; the exit edge is
  // the one that sees it at 1, so the state is visible for exactly that many cycles.
  assign expired = (cnt_q == CW'(1));

  // Next-state and timer logic for one bank.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_i == BCMD_ACT) begin
          state_d = ST_ACTIVATING;
          cnt_d   = CW'(T_RCD);
        end else if (cmd_i == BCMD_REF) begin
          state_d = ST_REFRESHING;
          cnt_d   = CW'(T_RFC);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVATING: begin
        if (expired) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACTIVE, ST_READING, ST_WRITING: begin
        // A new column command or precharge restarts the window and takes
        // priority over a read/write window ending on the same edge.
        case (cmd_i)
          BCMD_RD: begin
            state_d = ST_READING;
            cnt_d   = CW'(BL);
          end
          BCMD_RDA: begin
            state_d = ST_READING_AP;
            cnt_d   = CW'(BL);
          end
          BCMD_WR: begin
            state_d = ST_WRITING;
            cnt_d   = CW'(T_WR);
          end
          BCMD_WRA: begin
            state_d = ST_WRITING_AP;
            cnt_d   = CW'(T_WR);
          end
          BCMD_PR, BCMD_PRA: begin
            state_d = ST_PRECHARGING;
            cnt_d   = CW'(T_RP);
          end
          default: begin
            // ACTIVE has no timer running, so it just holds.
            if (state_q == ST_ACTIVE) begin
              state_d = ST_ACTIVE;
            end else if (expired) begin
              state_d = ST_ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        endcase
      end
      ST_READING_AP, ST_WRITING_AP: begin
        if (expired) begin
          state_d = ST_PRECHARGING;
          cnt_d   = CW'(T_RP);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PRECHARGING, ST_REFRESHING: begin
        if (expired) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and timer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/timing_fsm.sv
// -----------------------------------------------------------------------------
// timing_fsm
// Per-bank DRAM timing tracker. Resolves the one-hot command vector (highest
// set bit wins), routes it to the addressed bank (PRA to every bank) and
// exposes each bank's registered state code.
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  synchronous active-low reset
//   bg       in  bank group address (ignored when BGWIDTH = 0)
//   ba       in  bank address within group
//   commands in  19-bit one-hot command, ACT = bit 18 ... WRA = bit 0
//   BankFSM  out [group][bank] 5-bit state codes
// -----------------------------------------------------------------------------
module timing_fsm
  import timing_fsm_pkg::*;
#(
  parameter int unsigned BGWIDTH = 2,
  parameter int unsigned BAWIDTH = 2,
  parameter int unsigned BL      = 8,
  parameter int unsigned T_RCD   = 17,
  parameter int unsigned T_CL    = 17,
  parameter int unsigned T_WR    = 14,
  parameter int unsigned T_RP    = 17,
  parameter int unsigned T_RFC   = 34
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]               bg,
  input  logic [BAWIDTH-1:0]                                    ba,
  input  logic [CMD_NUM-1:0]                                    commands,
  output logic [(2**BGWIDTH)-1:0][(2**BAWIDTH)-1:0][4:0]         BankFSM
);

  localparam int unsigned BGW           = (BGWIDTH > 0) ? BGWIDTH : 1;
  localparam int unsigned BANKGROUPS    = 2 ** BGWIDTH;
  localparam int unsigned BANKSPERGROUP = 2 ** BAWIDTH;
  // One counter width for every bank, covering all timing parameters.
  localparam int unsigned CW = cnt_width(BL, T_RCD, T_CL, T_WR, T_RP, T_RFC);

  logic [4:0] win_idx;
  logic       win_vld;
  bank_cmd_e  win_cmd;

  // Highest-index set bit wins: later loop iterations overwrite earlier ones.
  always_comb begin
    win_idx = 5'd0;
    win_vld = 1'b0;
    for (int i = 0; i < CMD_NUM; i++) begin
      win_vld = win_vld | commands[i];
      win_idx = commands[i] ? 5'(i) : win_idx;
    end
  end

  // Map the winning bit to the reduced bank command set.
  always_comb begin
    win_cmd = BCMD_NONE;
    if (win_vld) begin
      case (win_idx)
        CMD_ACT: win_cmd = BCMD_ACT;
        CMD_PR:  win_cmd = BCMD_PR;
        CMD_PRA: win_cmd = BCMD_PRA;
        CMD_RD:  win_cmd = BCMD_RD;
        CMD_RDA: win_cmd = BCMD_RDA;
        CMD_REF: win_cmd = BCMD_REF;
        CMD_WR:  win_cmd = BCMD_WR;
        CMD_WRA: win_cmd = BCMD_WRA;
        default: win_cmd = BCMD_NONE;
      endcase
    end else begin
      win_cmd = BCMD_NONE;
    end
  end

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
      logic      sel;
      bank_cmd_e bank_cmd;

      assign sel = ((BGWIDTH == 0) || (bg == BGW'(g))) && (ba == BAWIDTH'(b));
      // PRA is broadcast; every other command only reaches the addressed bank.
      assign bank_cmd = (win_cmd == BCMD_PRA) ? BCMD_PRA :
                        (sel ? win_cmd : BCMD_NONE);

      bank_timing #(
        .BL    (BL),
        .T_RCD (T_RCD),
        .T_WR  (T_WR),
        .T_RP  (T_RP),
        .T_RFC (T_RFC),
        .CW    (CW)
      ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd_i   (bank_cmd),
        .state_o (BankFSM[g][b])
      );
    end
  end

endmodule

// File: tb/tb_timing_fsm.sv
// -----------------------------------------------------------------------------
// tb_timing_fsm
// Scoreboard bench: every driven cycle pushes the reference model's expected
// bank array; a negedge monitor pops and compares. Directed test-plan
// sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_timing_fsm;

  localparam int NB    = 16;
  localparam int BL    = 8;
  localparam int T_RCD = 17;
  localparam int T_WR  = 14;
  localparam int T_RP  = 17;
  localparam int T_RFC = 34;

  localparam int B_ACT = 18, B_BST = 17, B_MRR = 11, B_PR = 7, B_PRA = 6;
  localparam int B_RD = 5, B_RDA = 4, B_REF = 3, B_WR = 1, B_WRA = 0;

  localparam int S_IDLE = 8'h00, S_ACTIVATING = 8'h01, S_ACTIVE = 8'h03;
  localparam int S_PRECHARGING = 8'h0a, S_READING = 8'h0b, S_READING_AP = 8'h0c;
  localparam int S_REFRESHING = 8'h0d, S_WRITING = 8'h12, S_WRITING_AP = 8'h13;

  typedef logic [3:0][3:0][4:0] vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  bg, ba;
  logic [18:0] commands;
  vec_t        bank_fsm;

  timing_fsm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bg       (bg),
    .ba       (ba),
    .commands (commands),
    .BankFSM  (bank_fsm)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per bank, current phase and the absolute edge at which it ends.
  int mstate[NB];
  int mend[NB];
  int edge_no = 0;

  function automatic logic [18:0] cbit(input int i);
    logic [18:0] one;
    one = 19'd1;
    return one << i;
  endfunction

  function automatic void enter(input int k, input int st, input int dur);
    mstate[k] = st;
    mend[k]   = edge_no + dur;
  endfunction

  function automatic void model_edge(input logic [18:0] c, input int g, input int b, input logic rst);
    int win, cmd, s;
    bit acc;
    edge_no++;
    if (!rst) begin
      for (int k = 0; k < NB; k++) begin
        mstate[k] = S_IDLE;
        mend[k]   = 0;
      end
      return;
    end
    win = -1;
    for (int i = 0; i < 19; i++) if (c[i]) win = i;
    for (int k = 0; k < NB; k++) begin
      cmd = (win == B_PRA) ? B_PRA : ((k == g * 4 + b) ? win : -1);
      s   = mstate[k];
      acc = 1'b0;
      if (s == S_IDLE) begin
        if (cmd == B_ACT) begin enter(k, S_ACTIVATING, T_RCD); acc = 1'b1; end
        else if (cmd == B_REF) begin enter(k, S_REFRESHING, T_RFC); acc = 1'b1; end
      end else if (s == S_ACTIVE || s == S_READING || s == S_WRITING) begin
        acc = 1'b1;
        if (cmd == B_RD) enter(k, S_READING, BL);
        else if (cmd == B_RDA) enter(k, S_READING_AP, BL);
        else if (cmd == B_WR) enter(k, S_WRITING, T_WR);
        else if (cmd == B_WRA) enter(k, S_WRITING_AP, T_WR);
        else if (cmd == B_PR || cmd == B_PRA) enter(k, S_PRECHARGING, T_RP);
        else acc = 1'b0;
      end
      if (!acc && edge_no == mend[k]) begin
        if (s == S_ACTIVATING || s == S_READING || s == S_WRITING) enter(k, S_ACTIVE, 0);
        else if (s == S_READING_AP || s == S_WRITING_AP) enter(k, S_PRECHARGING, T_RP);
        else if (s == S_PRECHARGING || s == S_REFRESHING) enter(k, S_IDLE, 0);
      end
    end
  endfunction

  function automatic vec_t model_vec();
    vec_t v;
    for (int k = 0; k < NB; k++) v[k / 4][k % 4] = 5'(mstate[k]);
    return v;
  endfunction

  // Drive one cycle of stimulus, advance the model on the edge, queue the expectation.
  task automatic step(input logic [18:0] c, input int g, input int b, input logic rst = 1'b1);
    commands = c;
    bg       = 2'(g);
    ba       = 2'(b);
    reset_n  = rst;
    @(posedge clk);
    model_edge(c, g, b, rst);
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(19'd0, 0, 0);
  endtask

  // Directed check of one bank against a literal from the test plan.
  task automatic expect_bank(input string name, input int g, input int b, input logic [4:0] v);
    checks++;
    if (bank_fsm[g][b] !== v) begin
      errors++;
      $display("FAIL %s: bank[%0d][%0d] got 0x%02h expected 0x%02h", name, g, b, bank_fsm[g][b], v);
    end
  endtask

  // Monitor: the bank array is presented every cycle; compare against the queue.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bank_fsm !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got %h expected %h", $time, bank_fsm, e);
        end
      end
    end
  end

  initial begin
    int r, g, b;
    logic [18:0] c;
    logic rst;
    reset_n  = 1'b0;
    commands = 19'd0;
    bg = 2'd0;
    ba = 2'd0;
    for (int k = 0; k < NB; k++) begin mstate[k] = S_IDLE; mend[k] = 0; end

    // Reset, including a command presented while reset is held.
    repeat (3) step(19'd0, 0, 0, 1'b0);
    step(cbit(B_ACT), 1, 1, 1'b0);
    expect_bank("reset_state", 1, 1, 5'h00);

    // ACT to bank[1][1]: 17 cycles ACTIVATING then ACTIVE.
    step(cbit(B_ACT), 1, 1);
    expect_bank("act_enter", 1, 1, 5'h01);
    idle(16);
    expect_bank("act_last", 1, 1, 5'h01);
    expect_bank("act_other", 0, 0, 5'h00);
    idle(1);
    expect_bank("act_done", 1, 1, 5'h03);

    // WR, RD after 10, WR after 5, PR after 5, then precharge to IDLE.
    step(cbit(B_WR), 1, 1);
    expect_bank("wr", 1, 1, 5'h12);
    idle(9);
    step(cbit(B_RD), 1, 1);
    expect_bank("rd_turn", 1, 1, 5'h0b);
    idle(4);
    step(cbit(B_WR), 1, 1);
    expect_bank("wr_turn", 1, 1, 5'h12);
    idle(4);
    step(cbit(B_PR), 1, 1);
    expect_bank("pr", 1, 1, 5'h0a);
    idle(16);
    expect_bank("pr_last", 1, 1, 5'h0a);
    idle(1);
    expect_bank("pr_done", 1, 1, 5'h00);

    // REF for 34 cycles, ACT mid-refresh ignored.
    step(cbit(B_REF), 1, 1);
    expect_bank("ref", 1, 1, 5'h0d);
    idle(10);
    step(cbit(B_ACT), 1, 1);
    idle(22);
    expect_bank("ref_last", 1, 1, 5'h0d);
    idle(1);
    expect_bank("ref_done", 1, 1, 5'h00);

    // WRA: 14 cycles then auto-precharge 17 cycles.
    step(cbit(B_ACT), 1, 1);
    idle(17);
    step(cbit(B_WRA), 1, 1);
    expect_bank("wra", 1, 1, 5'h13);
    idle(13);
    expect_bank("wra_last", 1, 1, 5'h13);
    idle(1);
    expect_bank("wra_pre", 1, 1, 5'h0a);
    idle(16);
    expect_bank("wra_pre_last", 1, 1, 5'h0a);
    idle(1);
    expect_bank("wra_done", 1, 1, 5'h00);

    // RDA: 8 cycles then auto-precharge 17 cycles.
    step(cbit(B_ACT), 1, 1);
    idle(17);
    step(cbit(B_RDA), 1, 1);
    expect_bank("rda", 1, 1, 5'h0c);
    idle(7);
    expect_bank("rda_last", 1, 1, 5'h0c);
    idle(1);
    expect_bank("rda_pre", 1, 1, 5'h0a);
    idle(17);
    expect_bank("rda_done", 1, 1, 5'h00);

    // PRA with two active banks and one idle, then reset mid-precharge.
    step(cbit(B_ACT), 0, 0);
    step(cbit(B_ACT), 2, 3);
    idle(17);
    expect_bank("pra_pre_a", 0, 0, 5'h03);
    expect_bank("pra_pre_b", 2, 3, 5'h03);
    step(cbit(B_PRA), 3, 3);
    expect_bank("pra_a", 0, 0, 5'h0a);
    expect_bank("pra_b", 2, 3, 5'h0a);
    expect_bank("pra_idle", 1, 1, 5'h00);
    idle(5);
    step(19'd0, 0, 0, 1'b0);
    expect_bank("rst_mid_a", 0, 0, 5'h00);
    expect_bank("rst_mid_b", 2, 3, 5'h00);

    // Multi-hot: highest bit wins.
    step(cbit(B_ACT) | cbit(B_REF), 3, 0);
    expect_bank("prio_act_ref", 3, 0, 5'h01);
    idle(17);
    step(cbit(B_MRR) | cbit(B_RD), 3, 0);
    expect_bank("prio_mrr_rd", 3, 0, 5'h03);
    step(cbit(B_BST) | cbit(B_WR), 3, 0);
    expect_bank("prio_bst_wr", 3, 0, 5'h03);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      g = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if (r < 35) c = 19'd0;
      else if (r < 50) c = cbit(B_ACT);
      else if (r < 58) c = cbit(B_RD);
      else if (r < 64) c = cbit(B_RDA);
      else if (r < 72) c = cbit(B_WR);
      else if (r < 78) c = cbit(B_WRA);
      else if (r < 84) c = cbit(B_PR);
      else if (r < 88) c = cbit(B_REF);
      else if (r < 90) c = cbit(B_PRA);
      else c = cbit($urandom_range(0, 18));
      if ($urandom_range(0, 9) == 0) c = c | cbit($urandom_range(0, 18));
      step(c, g, b, rst);
    end

    // Drain: the last queued expectation is popped at the next negedge.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
